// File: rtl/operand_entry.sv
// -----------------------------------------------------------------------------
// operand_entry
//
// Front-end input stage for the calculator. Two bouncy active-low pushbuttons
// are synchronized and debounced. Each accepted press steps a four-state entry
// FSM that latches the shared switch bank into operand a, then operand b,
// then the 3-bit function code, and finally shows the result (valid = 1).
// A "clear" press zeroes everything and returns to operand a entry.
//
// Parameters
//   width       operand width (must match the calculator top)
//   deb_cycles  consecutive stable clocks needed to accept a key level change
//               (minimum 2)
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   sw           in   width  operand switches (asynchronous)
//   func_sw      in   3      function switches (asynchronous)
//   key_next_n   in   1      "enter/next" pushbutton, active-low, bouncy
//   key_clr_n    in   1      "clear" pushbutton, active-low, bouncy
//   a            out  width  registered operand A
//   b            out  width  registered operand B
//   func         out  3      registered function code
//   stage        out  2      0 LOAD_A, 1 LOAD_B, 2 LOAD_F, 3 SHOW
//   valid        out  1      high only in SHOW
//
// Build option
//   OPERAND_ENTRY_LIVE_PREVIEW_EN  when defined, the operand being entered
//   tracks the synchronized switches every cycle; the next press freezes it.
// -----------------------------------------------------------------------------
module operand_entry #(
    parameter int width      = 6,
    parameter int deb_cycles = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] sw,
    input  logic [2:0]       func_sw,
    input  logic             key_next_n,
    input  logic             key_clr_n,
    output logic [width-1:0] a,
    output logic [width-1:0] b,
    output logic [2:0]       func,
    output logic [1:0]       stage,
    output logic             valid
);

    localparam int CW = (deb_cycles > 1) ? $clog2(deb_cycles) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(deb_cycles - 1);

    // Key index 0 is "next", index 1 is "clear".
    localparam int KEY_NEXT = 0;
    localparam int KEY_CLR  = 1;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        LOAD_F = 2'd2,
        SHOW   = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // Two-flop synchronizers. Keys reset to 1 (released), switches to 0.
    // -------------------------------------------------------------------------
    logic [1:0]       key_meta_q, key_sync_q;
    logic [width-1:0] sw_meta_q, sw_sync_q;
    logic [2:0]       fsw_meta_q, fsw_sync_q;

    // NOTE: every clocked block uses non-blocking (<=) assignments so that all
    // flops sample their inputs from the same edge; blocking assignments here
    // would collapse the two synchronizer stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= 2'b11;
            key_sync_q <= 2'b11;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            fsw_meta_q <= '0;
            fsw_sync_q <= '0;
        end else begin
            key_meta_q <= {key_clr_n, key_next_n};
            key_sync_q <= key_meta_q;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            fsw_meta_q <= func_sw;
            fsw_sync_q <= fsw_meta_q;
        end
    end

    // -------------------------------------------------------------------------
    // Debouncers: the accepted level only follows the synchronized key after
    // it has disagreed for deb_cycles consecutive clocks.
    // -------------------------------------------------------------------------
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    deb_q, deb_d;
    logic [1:0]    deb_dly_q;
    logic [1:0]    press_q, press_d;

    // NOTE: each combinational block assigns every output a default first, so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            if (key_sync_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = key_sync_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Press pulse is one cycle after the debounced level falls; releases
    // (0 -> 1) produce nothing.
    assign press_d = deb_dly_q & ~deb_q;

    // NOTE: the two-entry counter array is an ordinary register bank, not a
    // RAM, so it is reset with everything else; a real memory would not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
            deb_q     <= 2'b11;
            deb_dly_q <= 2'b11;
            press_q   <= 2'b00;
        end else begin
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            press_q   <= press_d;
        end
    end

    logic next_ev, clr_ev;
    assign next_ev = press_q[KEY_NEXT];
    assign clr_ev  = press_q[KEY_CLR];

    // -------------------------------------------------------------------------
    // Entry FSM: state register, next-state logic, output logic.
    // -------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [width-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       func_q, func_d;
    logic             valid_q, valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear has priority over next when both pulse in the same cycle.
    always_comb begin
        state_d = state_q;
        if (clr_ev) begin
            state_d = LOAD_A;
        end else if (next_ev) begin
            case (state_q)
                LOAD_A:  state_d = LOAD_B;
                LOAD_B:  state_d = LOAD_F;
                LOAD_F:  state_d = SHOW;
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        func_d = func_q;
`ifdef OPERAND_ENTRY_LIVE_PREVIEW_EN
        // The field being entered follows the switches every cycle; the load
        // on the next event below is then simply the last tracked value.
        case (state_q)
            LOAD_A:  a_d    = sw_sync_q;
            LOAD_B:  b_d    = sw_sync_q;
            LOAD_F:  func_d = fsw_sync_q;
            default: ;
        endcase
`endif
        if (clr_ev) begin
            a_d    = '0;
            b_d    = '0;
            func_d = '0;
        end else if (next_ev) begin
            case (state_q)
                LOAD_A:  a_d    = sw_sync_q;
                LOAD_B:  b_d    = sw_sync_q;
                LOAD_F:  func_d = fsw_sync_q;
                default: ;  // SHOW -> LOAD_A keeps the values on display
            endcase
        end
        // valid is registered from the next state so it changes on the same
        // edge as the data and stage it qualifies.
        valid_d = (state_d == SHOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            func_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            func_q  <= func_d;
            valid_q <= valid_d;
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign func  = func_q;
    assign stage = state_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_operand_entry.sv
// -----------------------------------------------------------------------------
// tb_operand_entry
//
// Self-checking bench for operand_entry with deb_cycles = 4. A table of
// press operations with expected outputs covers the entry sequence; directed
// sequences cover reset, bounce rejection with exact latency, clear priority,
// reset during debounce and the live-preview option; a randomized phase is
// compared against an abstract model of the entry sequence.
// -----------------------------------------------------------------------------
module tb_operand_entry;

    localparam int W = 6;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw;
    logic [2:0]   func_sw;
    logic         key_next_n;
    logic         key_clr_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   func;
    logic [1:0]   stage;
    logic         valid;

    operand_entry #(.width(W), .deb_cycles(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .func_sw    (func_sw),
        .key_next_n (key_next_n),
        .key_clr_n  (key_clr_n),
        .a          (a),
        .b          (b),
        .func       (func),
        .stage      (stage),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- abstract model: one event = one step -------------------
    int m_stage, m_a, m_b, m_f;

    function automatic void model_reset();
        m_stage = 0; m_a = 0; m_b = 0; m_f = 0;
    endfunction

    function automatic void model_event(input bit nxt, input bit clr, input int swv, input int fv);
        if (clr) begin
            m_stage = 0; m_a = 0; m_b = 0; m_f = 0;
        end else if (nxt) begin
            if (m_stage == 0) m_a = swv;
            if (m_stage == 1) m_b = swv;
            if (m_stage == 2) m_f = fv;
            m_stage = (m_stage + 1) % 4;
        end
    endfunction

    // Value the field shows with settled switches: with preview, the field
    // being entered equals the current switches.
    function automatic int shown(input int field, input int stg, input int held, input int live);
        int r;
        r = held;
`ifdef OPERAND_ENTRY_LIVE_PREVIEW_EN
        if (stg == field) r = live;
`endif
        return r;
    endfunction

    task automatic check_model(input string tag, input int swv, input int fv);
        check({tag, ".a"},     32'(a),     shown(0, m_stage, m_a, swv));
        check({tag, ".b"},     32'(b),     shown(1, m_stage, m_b, swv));
        check({tag, ".func"},  32'(func),  shown(2, m_stage, m_f, fv));
        check({tag, ".stage"}, 32'(stage), m_stage);
        check({tag, ".valid"}, 32'(valid), (m_stage == 3) ? 1 : 0);
    endtask

    // ---------------- stimulus helpers --------------------------------------
    task automatic set_sw(input int swv, input int fv);
        @(negedge clk);
        sw      = W'(swv);
        func_sw = 3'(fv);
        repeat (3) @(negedge clk);
    endtask

    // Holds the key(s) low for 'hold' clocks, releases, then lets it settle.
    task automatic press(input bit nxt, input bit clr, input int hold);
        @(negedge clk);
        key_next_n = !nxt;
        key_clr_n  = !clr;
        repeat (hold) @(negedge clk);
        key_next_n = 1'b1;
        key_clr_n  = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // ---------------- vector table -------------------------------------------
    typedef struct {
        bit nxt;
        bit clr;
        int swv;
        int fv;
        int ea;
        int eb;
        int ef;
        int est;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        sw         = '0;
        func_sw    = '0;
        key_next_n = 1'b1;
        key_clr_n  = 1'b1;
        model_reset();

        tbl[0] = '{1, 0, 13, 0, 13, 0, 0, 1};
        tbl[1] = '{1, 0,  5, 0, 13, 5, 0, 2};
        tbl[2] = '{1, 0,  5, 3, 13, 5, 3, 3};
        tbl[3] = '{1, 0,  5, 3, 13, 5, 3, 0};
        tbl[4] = '{0, 1, 44, 6,  0, 0, 0, 0};
        tbl[5] = '{1, 0, 42, 6, 42, 0, 0, 1};

        repeat (3) @(negedge clk);
        check("por.a",     32'(a),     0);
        check("por.stage", 32'(stage), 0);
        check("por.valid", 32'(valid), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // ---- table: full entry sequence, hold in SHOW -> LOAD_A, clear ------
        for (int i = 0; i < 6; i++) begin
            set_sw(tbl[i].swv, tbl[i].fv);
            press(tbl[i].nxt, tbl[i].clr, 10);
            model_event(tbl[i].nxt, tbl[i].clr, tbl[i].swv, tbl[i].fv);
            check($sformatf("tbl%0d.a", i),     32'(a),     shown(0, tbl[i].est, tbl[i].ea, tbl[i].swv));
            check($sformatf("tbl%0d.b", i),     32'(b),     shown(1, tbl[i].est, tbl[i].eb, tbl[i].swv));
            check($sformatf("tbl%0d.func", i),  32'(func),  shown(2, tbl[i].est, tbl[i].ef, tbl[i].fv));
            check($sformatf("tbl%0d.stage", i), 32'(stage), tbl[i].est);
            check($sformatf("tbl%0d.valid", i), 32'(valid), (tbl[i].est == 3) ? 1 : 0);
        end

        // ---- reset mid-run and idle ------------------------------------------
        set_sw(0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst.a",     32'(a),     0);
        check("rst.b",     32'(b),     0);
        check("rst.func",  32'(func),  0);
        check("rst.stage", 32'(stage), 0);
        check("rst.valid", 32'(valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check_model("idle", 0, 0);

        // ---- bounce rejection, then exact press latency ----------------------
        set_sw(11, 0);
        for (int i = 0; i < 5; i++) begin
            key_next_n = 1'b0;
            repeat (3) @(negedge clk);
            key_next_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        check_model("bounce", 11, 0);

        key_next_n = 1'b0;
        @(posedge clk);                 // edge k
        repeat (6) @(posedge clk);      // edge k+6
        @(negedge clk);
        check("lat.before_k7", 32'(stage), 0);
        @(posedge clk);                 // edge k+7
        @(negedge clk);
        model_event(1, 0, 11, 0);
        check("lat.at_k7", 32'(stage), 1);
        check("lat.a",     32'(a),     11);
        repeat (92) @(negedge clk);
        check("hold.stage", 32'(stage), 1);
        key_next_n = 1'b1;
        repeat (10) @(negedge clk);
        check_model("hold", 11, 0);

        // ---- clear and next in the same cycle --------------------------------
        press(0, 1, 10);
        model_event(0, 1, 11, 0);
        set_sw(13, 0);
        press(1, 0, 10);
        model_event(1, 0, 13, 0);
        check("pri.a_loaded", 32'(a), 13);
        set_sw(9, 0);
        press(1, 1, 10);
        model_event(1, 1, 9, 0);
        check("pri.stage", 32'(stage), 0);
        check_model("pri", 9, 0);

        // ---- reset while a press is being debounced --------------------------
        set_sw(21, 0);
        press(1, 0, 10);
        model_event(1, 0, 21, 0);
        check("rdb.a_loaded", 32'(a), 21);
        set_sw(30, 0);
        key_next_n = 1'b0;
        @(posedge clk);                 // edge k
        repeat (3) @(posedge clk);      // counter now 2
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rdb.rst_a",     32'(a),     0);
        check("rdb.rst_stage", 32'(stage), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);                 // first post-reset sampling edge
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("rdb.before_k7", 32'(stage), 0);
        @(posedge clk);
        @(negedge clk);
        model_event(1, 0, 30, 0);
        check("rdb.stage", 32'(stage), 1);
        check("rdb.a",     32'(a),     30);
        key_next_n = 1'b1;
        repeat (10) @(negedge clk);
        check_model("rdb.after", 30, 0);

        // ---- live preview (or not) in LOAD_B ---------------------------------
        @(negedge clk);
        sw = W'(7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_model("preview", 7, 0);

        // ---- randomized presses and glitches ---------------------------------
        for (int it = 0; it < 40; it++) begin
            int swv, fv, op;
            swv = $urandom_range(0, 63);
            fv  = $urandom_range(0, 7);
            op  = $urandom_range(0, 9);
            set_sw(swv, fv);
            if (op == 0) begin
                press(0, 1, $urandom_range(8, 14));
                model_event(0, 1, swv, fv);
            end else if (op == 1) begin
                press(1, 0, $urandom_range(1, D - 1));
            end else if (op == 2) begin
                press(0, 1, $urandom_range(1, D - 1));
            end else begin
                press(1, 0, $urandom_range(8, 14));
                model_event(1, 0, swv, fv);
            end
            check_model($sformatf("rnd%0d", it), swv, fv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
